uart_wb_sequencer: RTL and testbench
====================================

# uart_wb_sequencer

Hardware sequencer that drives the wishbone slave port of the UART16550 (`uart_top`) on the 50 MHz bench clock. It programs the divisor and line format after reset, then executes a stream of send/expect byte commands, polling LSR for THRE and DR. It checks received bytes against expected values and reports pass/fail/timeout status. It replaces hand-written task sequences on the echo test path with one self-checking block.

## Interface

**Parameters**
- `DIVISOR`, default 16'd27: baud divisor for DLM:DLL (50 MHz, 115200 baud).
- `LCR_FMT`, default 8'h03: line format (8N1); DLAB is added internally during configuration.
- `TIMEOUT_CYC`, default 32'd200000: maximum clk_tb cycles spent in one poll phase.

**Ports**
- `clk_tb` in 1: clock.
- `reset_tb` in 1: reset, asynchronous, active-low.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: command accepted on the cycle where `cmd_valid` and `cmd_ready` are both high.
- `cmd_write` in 1: 1 = transmit `cmd_data`; 0 = expect `cmd_data` on receive.
- `cmd_data` in 8: byte to send or byte expected.
- `wb_adr_o` out 5: UART register address.
- `wb_dat_o` out 8: write data.
- `wb_dat_i` in 8: read data.
- `wb_sel_o` out 4: constant 4'b0001.
- `wb_cyc_o`, `wb_stb_o`, `wb_we_o` out 1: wishbone classic cycle controls.
- `wb_ack_i` in 1: slave acknowledge.
- `cfg_done` out 1: configuration complete (sticky until reset).
- `busy` out 1: not in IDLE.
- `fail` out 1: sticky; set by data mismatch or timeout.
- `timeout` out 1: sticky; set when any poll phase times out.
- `err_data` out 8: received byte from the first mismatch.
- `rx_count` out 16: number of expect commands completed, whether matched or not.

## Operation

**Reset values.** All outputs are 0, except `wb_sel_o` = 4'b0001. The state is CFG0.

**Configuration states** (one wishbone write each, in order):
- CFG0: LCR(3) ← `LCR_FMT` | 8'h80
- CFG1: DLL(0) ← `DIVISOR`[7:0]
- CFG2: DLM(1) ← `DIVISOR`[15:8]
- CFG3: LCR(3) ← `LCR_FMT`
- CFG4: FCR(2) ← 8'h07
- After CFG4, set `cfg_done` and go to IDLE.

**IDLE.** `cmd_ready` = 1 here only. On accept, latch the command.
- A write command goes to POLL_TX.
- An expect command goes to POLL_RX.

**POLL_TX.** Read LSR(5).
- If bit 5 (THRE) = 1, go to WR_THR.
- Otherwise, wait 8 idle cycles and re-read.

**WR_THR.** Write THR(0) ← the latched byte, then go to IDLE.

**POLL_RX.** Same polling scheme as POLL_TX, but on bit 0 (DR); when set, go to RD_RBR.

**RD_RBR.** Read RBR(0), increment `rx_count`, then compare.
- On mismatch: set `fail`; load `err_data` only if `fail` was previously 0.
- Return to IDLE.

**Timeout.** A 32-bit counter clears on entry to each POLL state and increments every cycle in it.
- Reaching `TIMEOUT_CYC` sets `timeout` and `fail`, abandons the command and returns to IDLE.
- A timeout does not increment `rx_count`.

**Sticky status.** `fail` and `timeout` never clear except by reset. Commands continue to be accepted after a fail.

**Counter wrap.** `rx_count` wraps modulo 2^16.

**Reset mid-operation.** All state is abandoned, the wishbone cycle drops immediately (asynchronously), and configuration reruns from CFG0 after release.

## Timing

**Wishbone transaction.**
- `cyc`, `stb`, `adr`, `dat_o` and `we` are asserted registered and held constant until `wb_ack_i` is sampled high.
- `cyc` and `stb` deassert on the next edge.
- There is at least 1 idle cycle between transactions.
- Read data is captured on the ack edge.
- No ack means a wait forever, except in POLL states, where the timeout also covers the outstanding read. On timeout the cycle is dropped.

**Latencies.**
- `cmd_ready` falls on the cycle after accept.
- `busy` is high from the cycle after accept until return to IDLE.
- With a 1-cycle ack, the minimum write command is 6 cycles from accept back to `cmd_ready`: LSR read, idle, THR write, idle.
- `fail` and `err_data` update on the edge after the RBR ack.
- `cfg_done` rises on the edge after the CFG4 ack, which is ≥ 10 cycles after reset release.

**Simultaneous events.** A `cmd_valid` asserted during configuration is held off (`cmd_ready` = 0); the command is not dropped.

## Structure

**Package `uart_seq_pkg`:**
- Register address constants: RBR/THR/DLL = 0, DLM = 1, FCR = 2, LCR = 3, LSR = 5.
- LSR bit indices: THRE = 5, DR = 0.
- DLAB mask 8'h80, FCR init value 8'h07.
- State enum: CFG0..CFG4, IDLE, POLL_TX, WR_THR, POLL_RX, RD_RBR.

**Sub-module `wb_single_xfer`:**
- Accepts a one-shot request (addr, data, we).
- Runs one classic wishbone cycle.
- Returns a `done` pulse and the read data.
- Supports `abort` for timeouts.
- The top-level FSM sequences it.

## Test plan

1. **Configuration.** Release reset with `uart_top` attached. Require the writes (3,8'h83), (0,8'h1B), (1,8'h00), (3,8'h03), (2,8'h07) in order, then `cfg_done` = 1.
2. **Loopback.** Loop `stx`→`srx` and issue write 8'h41 then expect 8'h41. Require `rx_count` = 1 and `fail` = 0.
3. **Echo stream.** Against the echo DUT, send "ABCDE" then expect "ABCDE". Require `rx_count` = 5 and `fail` = 0.
4. **Mismatch.** Send 8'h41, expect 8'h42. Require `fail` = 1 and `err_data` = 8'h41. A following mismatch leaves `err_data` unchanged.
5. **Timeout.** Set `TIMEOUT_CYC` = 1000 with `srx` tied high and issue expect 8'h41. Require `timeout` = `fail` = 1 within 1000 + 4 cycles, `wb_cyc_o` = 0, and `cmd_ready` = 1.
6. **Reset mid-operation.** Assert reset during the THR write's `wb_stb_o`. Require `wb_cyc_o` = 0 asynchronously, all status cleared, and a full configuration sequence after release.

Source files
------------

// File: rtl/uart_seq_pkg.sv
// Shared constants and types for the UART16550 wishbone sequencer.
package uart_seq_pkg;

  localparam logic [4:0] REG_RBR = 5'd0;
  localparam logic [4:0] REG_THR = 5'd0;
  localparam logic [4:0] REG_DLL = 5'd0;
  localparam logic [4:0] REG_DLM = 5'd1;
  localparam logic [4:0] REG_FCR = 5'd2;
  localparam logic [4:0] REG_LCR = 5'd3;
  localparam logic [4:0] REG_LSR = 5'd5;

  localparam int LSR_THRE = 5;
  localparam int LSR_DR   = 0;

  localparam logic [7:0] LCR_DLAB = 8'h80;
  localparam logic [7:0] FCR_INIT = 8'h07;

  // idle cycles between unsuccessful LSR polls
  localparam logic [3:0] POLL_GAP = 4'd8;

  typedef enum logic [3:0] {
    CFG0, CFG1, CFG2, CFG3, CFG4, IDLE, POLL_TX, WR_THR, POLL_RX, RD_RBR
  } seq_state_t;

  typedef struct packed {
    logic [4:0] adr;
    logic [7:0] dat;
    logic       we;
  } wb_req_t;

  function automatic logic is_poll(seq_state_t s);
    return (s == POLL_TX) || (s == POLL_RX);
  endfunction

endpackage

// File: rtl/wb_single_xfer.sv
// One classic wishbone cycle per go pulse; done pulses the cycle after the ack edge.
module wb_single_xfer
  import uart_seq_pkg::*;
(
  input  logic       clk_tb,
  input  logic       reset_tb,
  input  logic       go,
  input  wb_req_t    req,
  input  logic       abort,
  output logic       done,
  output logic [7:0] rdata,
  output logic [4:0] wb_adr,
  output logic [7:0] wb_dat,
  output logic       wb_cyc,
  output logic       wb_stb,
  output logic       wb_we,
  input  logic [7:0] wb_rdat,
  input  logic       wb_ack
);

  always_ff @(posedge clk_tb or negedge reset_tb) begin
    if (!reset_tb) begin
      wb_cyc <= 1'b0;
      wb_adr <= '0;
      wb_dat <= '0;
      wb_we  <= 1'b0;
      done   <= 1'b0;
      rdata  <= '0;
    end else begin
      done <= 1'b0;
      if (wb_cyc) begin
        if (abort) begin
          wb_cyc <= 1'b0;
          wb_we  <= 1'b0;
        end else if (wb_ack) begin
          wb_cyc <= 1'b0;
          wb_we  <= 1'b0;
          done   <= 1'b1;
          rdata  <= wb_rdat;
        end
      end else if (go) begin
        wb_cyc <= 1'b1;
        wb_adr <= req.adr;
        wb_dat <= req.dat;
        wb_we  <= req.we;
      end
    end
  end

  assign wb_stb = wb_cyc;

endmodule

// File: rtl/uart_wb_sequencer.sv
// Configures a UART16550 over wishbone, then runs send/expect byte commands
// with LSR polling, data checking and poll timeouts.
module uart_wb_sequencer
  import uart_seq_pkg::*;
#(
  parameter logic [15:0] DIVISOR     = 16'd27,
  parameter logic [7:0]  LCR_FMT     = 8'h03,
  parameter logic [31:0] TIMEOUT_CYC = 32'd200000
) (
  input  logic        clk_tb,
  input  logic        reset_tb,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [7:0]  cmd_data,
  output logic [4:0]  wb_adr_o,
  output logic [7:0]  wb_dat_o,
  input  logic [7:0]  wb_dat_i,
  output logic [3:0]  wb_sel_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  input  logic        wb_ack_i,
  output logic        cfg_done,
  output logic        busy,
  output logic        fail,
  output logic        timeout,
  output logic [7:0]  err_data,
  output logic [15:0] rx_count
);

  seq_state_t  state, state_n;
  logic [3:0]  gap;
  logic [31:0] tcnt;
  logic [7:0]  cmd_byte;
  logic        timed_out, poll_bit;
  logic        x_go, x_abort, x_done;
  logic [7:0]  x_rdata;
  wb_req_t     x_req;

  wb_single_xfer u_xfer (
    .clk_tb  (clk_tb),
    .reset_tb(reset_tb),
    .go      (x_go),
    .req     (x_req),
    .abort   (x_abort),
    .done    (x_done),
    .rdata   (x_rdata),
    .wb_adr  (wb_adr_o),
    .wb_dat  (wb_dat_o),
    .wb_cyc  (wb_cyc_o),
    .wb_stb  (wb_stb_o),
    .wb_we   (wb_we_o),
    .wb_rdat (wb_dat_i),
    .wb_ack  (wb_ack_i)
  );

  assign wb_sel_o  = 4'b0001;
  assign cmd_ready = (state == IDLE);
  assign poll_bit  = (state == POLL_TX) ? x_rdata[LSR_THRE] : x_rdata[LSR_DR];

  always_comb begin
    state_n   = state;
    timed_out = 1'b0;
    x_abort   = 1'b0;
    case (state)
      CFG0:    if (x_done) state_n = CFG1;
      CFG1:    if (x_done) state_n = CFG2;
      CFG2:    if (x_done) state_n = CFG3;
      CFG3:    if (x_done) state_n = CFG4;
      CFG4:    if (x_done) state_n = IDLE;
      IDLE:    if (cmd_valid) state_n = cmd_write ? POLL_TX : POLL_RX;
      POLL_TX, POLL_RX: begin
        if (tcnt >= TIMEOUT_CYC) begin
          timed_out = 1'b1;
          x_abort   = 1'b1;
          state_n   = IDLE;
        end else if (x_done && poll_bit) begin
          state_n = (state == POLL_TX) ? WR_THR : RD_RBR;
        end
      end
      WR_THR, RD_RBR: if (x_done) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // The next transfer launches in the done cycle of the previous one when the
  // state advances, so the bus sees exactly one idle cycle between them.
  always_comb begin
    x_go = 1'b0;
    if (state_n != IDLE)
      x_go = x_done ? (state_n != state)
                    : (!wb_cyc_o && gap == 4'd0 && state_n == state);
    x_req = '0;
    case (state_n)
      CFG0:    begin x_req.adr = REG_LCR; x_req.dat = LCR_FMT | LCR_DLAB; x_req.we = 1'b1; end
      CFG1:    begin x_req.adr = REG_DLL; x_req.dat = DIVISOR[7:0];       x_req.we = 1'b1; end
      CFG2:    begin x_req.adr = REG_DLM; x_req.dat = DIVISOR[15:8];      x_req.we = 1'b1; end
      CFG3:    begin x_req.adr = REG_LCR; x_req.dat = LCR_FMT;            x_req.we = 1'b1; end
      CFG4:    begin x_req.adr = REG_FCR; x_req.dat = FCR_INIT;           x_req.we = 1'b1; end
      POLL_TX, POLL_RX: x_req.adr = REG_LSR;
      WR_THR:  begin x_req.adr = REG_THR; x_req.dat = cmd_byte;           x_req.we = 1'b1; end
      RD_RBR:  x_req.adr = REG_RBR;
      default: x_req = '0;
    endcase
  end

  always_ff @(posedge clk_tb or negedge reset_tb) begin
    if (!reset_tb) begin
      state    <= CFG0;
      gap      <= '0;
      tcnt     <= '0;
      cmd_byte <= '0;
      cfg_done <= 1'b0;
      busy     <= 1'b0;
      fail     <= 1'b0;
      timeout  <= 1'b0;
      err_data <= '0;
      rx_count <= '0;
    end else begin
      state <= state_n;
      busy  <= (state_n != IDLE);
      if (state == IDLE && cmd_valid)
        cmd_byte <= cmd_data;

      if (state_n != state)
        tcnt <= '0;
      else if (is_poll(state))
        tcnt <= tcnt + 32'd1;

      if (state_n != state)
        gap <= '0;
      else if (is_poll(state) && x_done)
        gap <= POLL_GAP;
      else if (gap != 4'd0)
        gap <= gap - 4'd1;

      if (state == CFG4 && x_done)
        cfg_done <= 1'b1;

      if (timed_out) begin
        timeout <= 1'b1;
        fail    <= 1'b1;
      end

      if (state == RD_RBR && x_done) begin
        rx_count <= rx_count + 16'd1;
        if (x_rdata != cmd_byte) begin
          fail <= 1'b1;
          if (!fail)
            err_data <= x_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_wb_sequencer.sv
// Directed bench: a small UART register model with echo of THR into RBR.
module tb_uart_wb_sequencer;

  typedef struct {
    bit         we;
    logic [7:0] data;
    int         stall;
    logic [15:0] exp_rx;
    bit         exp_fail;
    logic [7:0] exp_err;
  } vec_t;

  logic        clk_tb = 1'b0;
  logic        reset_tb = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [7:0]  cmd_data = 8'h00;
  logic [4:0]  wb_adr_o;
  logic [7:0]  wb_dat_o;
  logic [7:0]  wb_dat_i;
  logic [3:0]  wb_sel_o;
  logic        wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i;
  logic        cfg_done, busy, fail, timeout;
  logic [7:0]  err_data;
  logic [15:0] rx_count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_tb = ~clk_tb;

  uart_wb_sequencer #(
    .DIVISOR    (16'd27),
    .LCR_FMT    (8'h03),
    .TIMEOUT_CYC(32'd1000)
  ) dut (
    .clk_tb   (clk_tb),
    .reset_tb (reset_tb),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_data (cmd_data),
    .wb_adr_o (wb_adr_o),
    .wb_dat_o (wb_dat_o),
    .wb_dat_i (wb_dat_i),
    .wb_sel_o (wb_sel_o),
    .wb_cyc_o (wb_cyc_o),
    .wb_stb_o (wb_stb_o),
    .wb_we_o  (wb_we_o),
    .wb_ack_i (wb_ack_i),
    .cfg_done (cfg_done),
    .busy     (busy),
    .fail     (fail),
    .timeout  (timeout),
    .err_data (err_data),
    .rx_count (rx_count)
  );

  // UART slave model: zero-wait ack, THRE held low for a programmable number
  // of LSR reads, THR writes echoed into the receive queue.
  logic       ack_en = 1'b1;
  logic [7:0] rxm [0:63];
  int         rhead = 0, rtail = 0;
  logic       dlab = 1'b0;
  int         lsr_reads = 0, thre_after = 0;
  logic [4:0] wadr [0:255];
  logic [7:0] wdat [0:255];
  int         wr_cnt = 0;

  assign wb_ack_i = wb_cyc_o & wb_stb_o & ack_en;

  always_comb begin
    wb_dat_i = 8'h00;
    if (wb_adr_o == 5'd5)
      wb_dat_i = {2'b00, (lsr_reads >= thre_after), 4'b0000, (rhead != rtail)};
    else if (wb_adr_o == 5'd0 && rhead != rtail)
      wb_dat_i = rxm[rhead[5:0]];
  end

  always @(posedge clk_tb) begin
    if (wb_ack_i) begin
      if (wb_we_o) begin
        wadr[wr_cnt[7:0]] <= wb_adr_o;
        wdat[wr_cnt[7:0]] <= wb_dat_o;
        wr_cnt <= wr_cnt + 1;
        if (wb_adr_o == 5'd3) dlab <= wb_dat_o[7];
        if (wb_adr_o == 5'd0 && !dlab) begin
          rxm[rtail[5:0]] <= wb_dat_o;
          rtail <= rtail + 1;
        end
      end else begin
        if (wb_adr_o == 5'd5) lsr_reads <= lsr_reads + 1;
        if (wb_adr_o == 5'd0 && !dlab && rhead != rtail) rhead <= rhead + 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic wait_ready(input int bound, output int cyc);
    cyc = 0;
    while (!cmd_ready && cyc < bound) begin
      @(negedge clk_tb);
      cyc++;
    end
  endtask

  task automatic issue(input bit we, input logic [7:0] d);
    int c;
    wait_ready(3000, c);
    chk("ready_before_cmd", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_write = we;
    cmd_data  = d;
    @(negedge clk_tb);
    cmd_valid = 1'b0;
  endtask

  task automatic check_cfg(input int base);
    logic [4:0] ea [5];
    logic [7:0] ed [5];
    ea = '{5'd3, 5'd0, 5'd1, 5'd3, 5'd2};
    ed = '{8'h83, 8'h1B, 8'h00, 8'h03, 8'h07};
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("cfg_adr%0d", k), wadr[(base + k) % 256], ea[k]);
      chk($sformatf("cfg_dat%0d", k), wdat[(base + k) % 256], ed[k]);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [17];
    int   n, lat, c, base, wbefore;

    tbl[0]  = '{1'b0, 8'h55, 0, 16'd1, 1'b0, 8'h00};
    tbl[1]  = '{1'b1, 8'h41, 0, 16'd1, 1'b0, 8'h00};
    tbl[2]  = '{1'b0, 8'h41, 0, 16'd2, 1'b0, 8'h00};
    tbl[3]  = '{1'b1, 8'h41, 0, 16'd2, 1'b0, 8'h00};
    tbl[4]  = '{1'b1, 8'h42, 0, 16'd2, 1'b0, 8'h00};
    tbl[5]  = '{1'b1, 8'h43, 2, 16'd2, 1'b0, 8'h00};
    tbl[6]  = '{1'b1, 8'h44, 0, 16'd2, 1'b0, 8'h00};
    tbl[7]  = '{1'b1, 8'h45, 0, 16'd2, 1'b0, 8'h00};
    tbl[8]  = '{1'b0, 8'h41, 0, 16'd3, 1'b0, 8'h00};
    tbl[9]  = '{1'b0, 8'h42, 0, 16'd4, 1'b0, 8'h00};
    tbl[10] = '{1'b0, 8'h43, 0, 16'd5, 1'b0, 8'h00};
    tbl[11] = '{1'b0, 8'h44, 0, 16'd6, 1'b0, 8'h00};
    tbl[12] = '{1'b0, 8'h45, 0, 16'd7, 1'b0, 8'h00};
    tbl[13] = '{1'b1, 8'h41, 0, 16'd7, 1'b0, 8'h00};
    tbl[14] = '{1'b0, 8'h42, 0, 16'd8, 1'b1, 8'h41};
    tbl[15] = '{1'b1, 8'h43, 0, 16'd8, 1'b1, 8'h41};
    tbl[16] = '{1'b0, 8'h44, 0, 16'd9, 1'b1, 8'h41};

    // A write command is offered from reset and must be held off until configured.
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_data  = 8'h55;
    repeat (2) @(negedge clk_tb);
    chk("rst_cyc", wb_cyc_o, 0);
    chk("rst_stb", wb_stb_o, 0);
    chk("rst_bus", {wb_we_o, wb_adr_o, wb_dat_o}, 0);
    chk("rst_sel", wb_sel_o, 4'b0001);
    chk("rst_status", {cfg_done, busy, fail, timeout, cmd_ready}, 0);
    chk("rst_counts", {err_data, rx_count}, 0);

    reset_tb = 1'b1;
    n = 0;
    while (!cmd_ready && n < 100) begin
      @(negedge clk_tb);
      n++;
    end
    chk("cfg_done_at_ready", cfg_done, 1);
    chk("cfg_min_cycles", (n >= 10), 1);
    chk("cfg_write_count", wr_cnt, 5);
    check_cfg(0);

    @(negedge clk_tb);
    cmd_valid = 1'b0;
    chk("ready_low_after_accept", cmd_ready, 0);
    chk("busy_after_accept", busy, 1);
    lat = 1;
    while (!cmd_ready && lat < 50) begin
      @(negedge clk_tb);
      lat++;
    end
    chk("write_latency", lat, 6);
    chk("thr_write_adr", wadr[5], 5'd0);
    chk("thr_write_dat", wdat[5], 8'h55);

    for (int i = 0; i < 17; i++) begin
      if (tbl[i].stall != 0) thre_after = lsr_reads + tbl[i].stall;
      issue(tbl[i].we, tbl[i].data);
      wait_ready(3000, c);
      chk($sformatf("v%0d_done", i), cmd_ready, 1);
      chk($sformatf("v%0d_rx_count", i), rx_count, tbl[i].exp_rx);
      chk($sformatf("v%0d_fail", i), fail, tbl[i].exp_fail);
      chk($sformatf("v%0d_err_data", i), err_data, tbl[i].exp_err);
      if (tbl[i].we) begin
        chk($sformatf("v%0d_thr_adr", i), wadr[(wr_cnt - 1) % 256], 5'd0);
        chk($sformatf("v%0d_thr_dat", i), wdat[(wr_cnt - 1) % 256], tbl[i].data);
      end
    end
    chk("no_timeout_yet", timeout, 0);

    // Expect with nothing ever arriving: LSR polls run out of time.
    issue(1'b0, 8'h41);
    n = 0;
    while (!timeout && n < 1004) begin
      @(negedge clk_tb);
      n++;
    end
    chk("rx_timeout_flag", timeout, 1);
    chk("rx_timeout_fail", fail, 1);
    chk("rx_timeout_cyc", wb_cyc_o, 0);
    chk("rx_timeout_ready", cmd_ready, 1);
    chk("rx_timeout_count", rx_count, 16'd9);

    // Slave never acks: the outstanding LSR read is abandoned.
    ack_en  = 1'b0;
    wbefore = wr_cnt;
    issue(1'b1, 8'h66);
    wait_ready(1100, c);
    chk("noack_ready", cmd_ready, 1);
    chk("noack_cyc", wb_cyc_o, 0);
    chk("noack_no_write", wr_cnt, wbefore);
    ack_en = 1'b1;

    // Reset lands while the THR write strobe is up.
    issue(1'b1, 8'h77);
    n = 0;
    while (!(wb_stb_o && wb_we_o && wb_adr_o == 5'd0) && n < 100) begin
      @(negedge clk_tb);
      n++;
    end
    chk("thr_strobe_seen", wb_stb_o, 1);
    #2 reset_tb = 1'b0;
    #1;
    chk("async_cyc_drop", wb_cyc_o, 0);
    chk("async_stb_drop", wb_stb_o, 0);
    chk("midrst_status", {cfg_done, busy, fail, timeout, cmd_ready}, 0);
    chk("midrst_counts", {err_data, rx_count}, 0);
    base = wr_cnt;
    @(negedge clk_tb);
    reset_tb = 1'b1;
    n = 0;
    while (!cfg_done && n < 100) begin
      @(negedge clk_tb);
      n++;
    end
    chk("recfg_done", cfg_done, 1);
    chk("recfg_write_count", wr_cnt - base, 5);
    check_cfg(base);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
